// File: rtl/traffic_generator_pkg.sv
// Shared types for the enqueue-side traffic generator: packet fields,
// configuration record, FSM states and the priority-shaping helper.
package traffic_generator_pkg;

  typedef logic [7:0]  PacketPointer;
  typedef logic [7:0]  Priority;
  typedef logic [7:0]  InjectionRate;
  typedef logic [15:0] CounterSignal;

  typedef enum logic [1:0] {
    CONST  = 2'd0,
    INCR   = 2'd1,
    DECR   = 2'd2,
    RANDOM = 2'd3
  } TGPrioMode;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } TGState;

  typedef struct packed {
    InjectionRate injrate;
    InjectionRate injrate_seed;
    Priority      prio_seed;
    TGPrioMode    prio_mode;
    Priority      prio_base;
    Priority      prio_mask;
    CounterSignal num_packets;
  } TGConfig;

  localparam CounterSignal COUNTER_ONE = 16'd1;

  // Priority of the packet currently presented, all arithmetic wraps at
  // the Priority width.
  function automatic Priority tg_priority(
    input TGPrioMode mode,
    input Priority   base,
    input Priority   mask,
    input Priority   seq_ext,
    input Priority   lfsr_val
  );
    Priority result;
    case (mode)
      CONST:   result = base;
      INCR:    result = base + seq_ext;
      DECR:    result = base - seq_ext;
      RANDOM:  result = base + (lfsr_val & mask);
      default: result = base;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/traffic_generator_lfsr.sv
// Galois LFSR with seed load on reset and a step enable. A zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module linear_feedback_shift_register #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i__enable,
  input  logic [NUM_BITS-1:0] i__seed,
  output logic [NUM_BITS-1:0] o__value
);

  // Maximal-length feedback masks for the common widths; other widths
  // get a simple (non-maximal) two-tap fallback.
  function automatic logic [31:0] galois_taps(input int n);
    logic [31:0] taps;
    case (n)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_B400;
      32:      taps = 32'h8020_0003;
      default: taps = (32'h0000_0001 << (n - 1)) | 32'h0000_0001;
    endcase
    return taps;
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(galois_taps(NUM_BITS));

  logic [NUM_BITS-1:0] lfsr_r;
  logic [NUM_BITS-1:0] lfsr_next_s;
  logic [NUM_BITS-1:0] seed_s;

  // Guard against the lock-up seed.
  always_comb begin
    seed_s = i__seed;
    if (i__seed == {NUM_BITS{1'b0}}) begin
      seed_s = {{(NUM_BITS-1){1'b0}}, 1'b1};
    end else begin
      seed_s = i__seed;
    end
  end

  // One Galois step: shift right, fold the feedback mask in when the
  // outgoing bit is set.
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[NUM_BITS-1:1]};
    if (lfsr_r[0]) begin
      lfsr_next_s = {1'b0, lfsr_r[NUM_BITS-1:1]} ^ TAPS;
    end else begin
      lfsr_next_s = {1'b0, lfsr_r[NUM_BITS-1:1]};
    end
  end

  // State register: reload the seed on reset, step when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= seed_s;
    end else if (i__enable) begin
      lfsr_r <= lfsr_next_s;
    end
  end

  assign o__value = lfsr_r;

endmodule

// File: rtl/traffic_generator.sv
// Enqueue-side packet source for the PIFO bench: issues {id, seq} pointers
// with shaped priorities at an LFSR-throttled rate until a packet budget
// is spent, then reports completion.
module traffic_generator
  import traffic_generator_pkg::*;
#(
  parameter int TG_ID   = 0,
  parameter int ID_BITS = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  TGConfig      i__config,
  input  logic         i__inject_phase,
  input  logic         i__pifo_ready,
  output logic         o__enqueue,
  output PacketPointer o__packet_pointer,
  output Priority      o__packet_priority,
  output CounterSignal o__num_pkts_sent,
  output logic         o__done
);

  localparam int SEQ_BITS = $bits(PacketPointer) - ID_BITS;
  localparam logic [ID_BITS-1:0]  TG_ID_FIELD = ID_BITS'(TG_ID);
  localparam logic [SEQ_BITS-1:0] SEQ_ONE     = {{(SEQ_BITS-1){1'b0}}, 1'b1};
  localparam InjectionRate        RATE_FULL   = {$bits(InjectionRate){1'b1}};

  TGState        state_r;
  TGState        state_next_s;
  logic [SEQ_BITS-1:0] seq_r;
  CounterSignal  sent_r;
  logic          done_r;

  InjectionRate  lfsr_inj_s;
  Priority       lfsr_prio_s;
  logic          rate_ok_s;
  logic          fire_s;
  logic          inj_adv_s;
  CounterSignal  sent_plus_one_s;

  // Injection-rate throttle and firing condition. Reset masks the strobe
  // so an aborted run never emits a packet in the reset cycle.
  always_comb begin
    rate_ok_s       = (i__config.injrate == RATE_FULL) ||
                      (lfsr_inj_s < i__config.injrate);
    inj_adv_s       = !reset && (state_r == ACTIVE) && i__inject_phase;
    fire_s          = inj_adv_s && i__pifo_ready && rate_ok_s;
    sent_plus_one_s = sent_r + COUNTER_ONE;
  end

  // Next-state logic for IDLE -> ACTIVE -> DONE; a zero budget never ends.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i__inject_phase) begin
          state_next_s = ACTIVE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACTIVE: begin
        if (fire_s && (i__config.num_packets != 16'd0) &&
            (sent_plus_one_s == i__config.num_packets)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      DONE:    state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM, sequence number, sent counter and sticky completion flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      seq_r   <= {SEQ_BITS{1'b0}};
      sent_r  <= 16'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == DONE);
      if (fire_s) begin
        seq_r  <= seq_r + SEQ_ONE;
        sent_r <= sent_plus_one_s;
      end
    end
  end

  linear_feedback_shift_register #(
    .NUM_BITS ($bits(InjectionRate))
  ) lfsr_injrate (
    .clk       (clk),
    .reset     (reset),
    .i__enable (inj_adv_s),
    .i__seed   (i__config.injrate_seed),
    .o__value  (lfsr_inj_s)
  );

  linear_feedback_shift_register #(
    .NUM_BITS ($bits(Priority))
  ) lfsr_prio (
    .clk       (clk),
    .reset     (reset),
    .i__enable (fire_s),
    .i__seed   (i__config.prio_seed),
    .o__value  (lfsr_prio_s)
  );

  assign o__enqueue         = fire_s;
  assign o__packet_pointer  = {TG_ID_FIELD, seq_r};
  assign o__packet_priority = tg_priority(i__config.prio_mode,
                                          i__config.prio_base,
                                          i__config.prio_mask,
                                          Priority'(seq_r),
                                          lfsr_prio_s);
  assign o__num_pkts_sent   = sent_r;
  assign o__done            = done_r;

endmodule

// File: tb/tb_traffic_generator.sv
// Self-checking bench for traffic_generator: table-driven scenarios with a
// cycle-level reference model feeding a packet scoreboard, plus hand-written
// sequences for mid-run reset and the final-fire/phase-drop coincidence.
module tb_traffic_generator;
  import traffic_generator_pkg::*;

  localparam int TB_ID = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  TGConfig      cfg;
  logic         phase = 1'b0;
  logic         ready = 1'b0;
  logic         enqueue;
  PacketPointer pointer;
  Priority      prio;
  CounterSignal num_sent;
  logic         done;

  traffic_generator #(.TG_ID(TB_ID), .ID_BITS(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .i__config          (cfg),
    .i__inject_phase    (phase),
    .i__pifo_ready      (ready),
    .o__enqueue         (enqueue),
    .o__packet_pointer  (pointer),
    .o__packet_priority (prio),
    .o__num_pkts_sent   (num_sent),
    .o__done            (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] ptr;
    logic [7:0] pri;
  } pkt_t;
  pkt_t sb_q[$];

  // Reference model state
  TGState      m_state;
  logic [5:0]  m_seq;
  logic [15:0] m_sent;
  logic [7:0]  m_inj;
  logic [7:0]  m_prio;
  logic        m_done;
  int          cyc_idx;
  int          first_done;

  typedef struct {
    logic [7:0]  injrate;
    logic [7:0]  inj_seed;
    logic [7:0]  prio_seed;
    TGPrioMode   mode;
    logic [7:0]  base;
    logic [7:0]  mask;
    logic [15:0] num;
    int          cycles;
    int          ready_mode;   // 0: always ready, 1: ready on odd cycles
    int          pause_start;
    int          pause_len;
    int          exp_sent;     // -1: not checked
    int          exp_done;
    int          exp_done_cycle; // -1: never, -2: not checked
  } row_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] model_prio();
    logic [7:0] p;
    case (cfg.prio_mode)
      CONST:   p = cfg.prio_base;
      INCR:    p = cfg.prio_base + {2'b00, m_seq};
      DECR:    p = cfg.prio_base - {2'b00, m_seq};
      RANDOM:  p = cfg.prio_base + (m_prio & cfg.prio_mask);
      default: p = cfg.prio_base;
    endcase
    return p;
  endfunction

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic cycle(input logic rst, input logic ph, input logic rdy);
    logic m_rate, m_fire;
    pkt_t got;
    reset = rst; phase = ph; ready = rdy;
    #1;
    m_rate = (cfg.injrate == 8'hFF) || (m_inj < cfg.injrate);
    m_fire = !rst && (m_state == ACTIVE) && ph && rdy && m_rate;
    if (m_fire) sb_q.push_back('{ptr: {2'(TB_ID), m_seq}, pri: model_prio()});
    check("enqueue", {31'd0, enqueue}, {31'd0, m_fire});
    if (enqueue) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pkt", 32'd1, 32'd0);
      end else begin
        got = sb_q.pop_front();
        check("pointer", {24'd0, pointer}, {24'd0, got.ptr});
        check("priority", {24'd0, prio}, {24'd0, got.pri});
      end
    end
    check("num_sent", {16'd0, num_sent}, {16'd0, m_sent});
    check("done", {31'd0, done}, {31'd0, m_done});
    if (done && first_done < 0) first_done = cyc_idx;
    @(posedge clk);
    if (rst) begin
      m_state = IDLE; m_seq = 6'd0; m_sent = 16'd0; m_done = 1'b0;
      m_inj = cfg.injrate_seed; m_prio = cfg.prio_seed;
    end else begin
      if (m_state == IDLE && ph) begin
        m_state = ACTIVE;
      end else if (m_state == ACTIVE) begin
        if (ph) m_inj = lstep(m_inj);
        if (m_fire) begin
          if (cfg.num_packets != 16'd0 && m_sent + 16'd1 == cfg.num_packets) m_state = DONE;
          m_seq  = m_seq + 6'd1;
          m_sent = m_sent + 16'd1;
          m_prio = lstep(m_prio);
        end
      end
      m_done = (m_state == DONE);
    end
    cyc_idx++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cyc_idx    = 0;
    first_done = -1;
  endtask

  task automatic load_cfg(input row_t r);
    cfg.injrate      = r.injrate;
    cfg.injrate_seed = r.inj_seed;
    cfg.prio_seed    = r.prio_seed;
    cfg.prio_mode    = r.mode;
    cfg.prio_base    = r.base;
    cfg.prio_mask    = r.mask;
    cfg.num_packets  = r.num;
  endtask

  task automatic run_row(input row_t r);
    logic ph, rdy;
    load_cfg(r);
    do_reset();
    for (int c = 0; c < r.cycles; c++) begin
      ph  = !(c >= r.pause_start && c < r.pause_start + r.pause_len);
      rdy = (r.ready_mode == 0) ? 1'b1 : c[0];
      cycle(1'b0, ph, rdy);
    end
    if (r.exp_sent >= 0) check("row_sent", {16'd0, num_sent}, r.exp_sent);
    check("row_done", {31'd0, done}, r.exp_done);
    if (r.exp_done_cycle != -2) check("row_done_cycle", first_done, r.exp_done_cycle);
    check("row_sb_empty", sb_q.size(), 32'd0);
  endtask

  row_t rows[8];

  initial begin
    //          inj    iseed  pseed  mode    base    mask   num     cyc rdy pst plen sent done dcyc
    rows[0] = '{8'hFF, 8'h01, 8'h01, CONST,  8'd5,   8'h00, 16'd4,  8,  0, -1, 0,   4,   1,   5};
    rows[1] = '{8'h00, 8'h2B, 8'h01, CONST,  8'd9,   8'h00, 16'd3,  100,0, -1, 0,   0,   0,  -1};
    rows[2] = '{8'hFF, 8'h01, 8'h01, INCR,   8'd250, 8'h00, 16'd10, 14, 0, -1, 0,  10,   1,  11};
    rows[3] = '{8'hFF, 8'h01, 8'h01, INCR,   8'd0,   8'h00, 16'd6,  16, 1, -1, 0,   6,   1,  12};
    rows[4] = '{8'hFF, 8'h01, 8'h6D, RANDOM, 8'd3,   8'hFF, 16'd6,  16, 0,  3, 5,   6,   1,  12};
    rows[5] = '{8'hFF, 8'h01, 8'h01, CONST,  8'd1,   8'h00, 16'd0,  40, 0, -1, 0,  39,   0,  -1};
    rows[6] = '{8'h80, 8'h5A, 8'h3C, RANDOM, 8'd0,   8'hFF, 16'd0,  60, 0, 20, 5,  -1,   0,  -1};
    rows[7] = '{8'h40, 8'h77, 8'h01, DECR,   8'd2,   8'h00, 16'd0,  40, 1, -1, 0,  -1,   0,  -1};

    cfg = '0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_row(rows[i]);

    // Mid-run reset: abort after three sends, then rerun from the seeds.
    begin
      row_t rr;
      int guard;
      rr = '{8'hC0, 8'hA5, 8'h33, RANDOM, 8'h10, 8'h0F, 16'd0, 0, 0, -1, 0, -1, 0, -2};
      load_cfg(rr);
      do_reset();
      guard = 0;
      while (m_sent != 16'd3 && guard < 200) begin
        cycle(1'b0, 1'b1, 1'b1);
        guard++;
      end
      check("reset_run_bound", {31'd0, guard < 200}, 32'd1);
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      reset = 1'b0; phase = 1'b1; ready = 1'b1;
      #1;
      check("post_reset_sent", {16'd0, num_sent}, 32'd0);
      check("post_reset_done", {31'd0, done}, 32'd0);
      check("post_reset_enq", {31'd0, enqueue}, 32'd0);
      check("post_reset_ptr", {24'd0, pointer}, 32'h80);
      for (int c = 0; c < 30; c++) cycle(1'b0, 1'b1, 1'b1);
      check("rerun_sb_empty", sb_q.size(), 32'd0);
    end

    // Final enqueue coincides with the last phase-high cycle.
    begin
      row_t rs;
      rs = '{8'hFF, 8'h01, 8'h01, CONST, 8'd7, 8'h00, 16'd3, 0, 0, -1, 0, -1, 0, -2};
      load_cfg(rs);
      do_reset();
      for (int c = 0; c < 7; c++) cycle(1'b0, (c <= 3), 1'b1);
      check("drop_done_cycle", first_done, 32'd4);
      check("drop_sent", {16'd0, num_sent}, 32'd3);
      check("drop_done", {31'd0, done}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_generator.md
Name: traffic_generator

Overview:
Testbench-side packet source that drives the enqueue side of the PIFO under test, the counterpart of traffic_receiver on the dequeue side. It emits one packet (pointer + priority) per accepted enqueue at an LFSR-throttled injection rate, stops after a configured packet budget, and reports count and completion to the bench controller.

Parameters:
TG_ID, 0, source identifier placed in the upper bits of every generated PacketPointer.
ID_BITS, 2, width of the TG_ID field; the remaining low PacketPointer bits form the sequence number SEQ_BITS = $bits(PacketPointer) - ID_BITS.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
i__config  input  $bits(TGConfig)  static configuration, held stable while not in reset.
i__inject_phase  input  1  bench phase enable; generation is allowed only while high.
i__pifo_ready  input  1  PIFO can accept an enqueue this cycle.
o__enqueue  output  1  enqueue strobe, valid in the same cycle as pointer and priority.
o__packet_pointer  output  $bits(PacketPointer)  {TG_ID, seq}.
o__packet_priority  output  $bits(Priority)  priority of the current packet.
o__num_pkts_sent  output  $bits(CounterSignal)  count of accepted enqueues.
o__done  output  1  packet budget exhausted; sticky until reset.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: state IDLE, seq 0, sent 0, o__done 0, o__enqueue 0. Both LFSRs reload their seeds. Reset asserted mid-run aborts the run immediately; no partial state survives.
- FSM states are IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on the first cycle with i__inject_phase = 1. No enqueue is issued in that cycle.
  - ACTIVE -> DONE on the cycle in which an enqueue fires and sent+1 == num_packets.
  - DONE is terminal until reset.
  - num_packets == 0 means unlimited: the block stays in ACTIVE indefinitely.
- Rate check, evaluated combinationally: rate_ok = (injrate == all-ones) || (lfsr_inj < injrate).
  - injrate 0 means never inject.
  - injrate all-ones means inject every ready cycle.
- Firing rule, combinational: fire = (state == ACTIVE) && i__inject_phase && i__pifo_ready && rate_ok. o__enqueue = fire.
- lfsr_inj advances on every cycle where state == ACTIVE and i__inject_phase = 1, whether or not the enqueue fires. It must never stall.
- Pausing: i__inject_phase low while in ACTIVE pauses the block. State, seq, sent and both LFSRs all hold.
- On fire: seq <= seq+1 (wraps modulo 2^SEQ_BITS, no saturation); sent <= sent+1; lfsr_prio advances.
- o__packet_pointer = {TG_ID[ID_BITS-1:0], seq}, driven continuously. It is only meaningful when o__enqueue = 1.
- o__packet_priority is combinational from the registered state, by prio_mode. All arithmetic is truncated to $bits(Priority) and wraps.
  - CONST: prio_base.
  - INCR: prio_base + seq.
  - DECR: prio_base - seq.
  - RANDOM: prio_base + (lfsr_prio & prio_mask).
- o__num_pkts_sent: registered sent count. It wraps at the CounterSignal width; num_packets must not exceed that range.
- o__done = (state == DONE), registered.
- Simultaneous events: if the final enqueue fires in the same cycle as i__inject_phase falling, the fire still counts and the block enters DONE.
- i__pifo_ready low with all other fire conditions true: no enqueue, seq holds, lfsr_inj still advances.

Decomposition:
- Package pifo_tb_headers.vh gains:
  - TGConfig struct: injrate (InjectionRate), injrate_seed, prio_seed, prio_mode (TGPrioMode), prio_base (Priority), prio_mask (Priority), num_packets (CounterSignal).
  - TGPrioMode enum: CONST, INCR, DECR, RANDOM.
  - TGState enum: IDLE, ACTIVE, DONE.
- Sub-module: the existing linear_feedback_shift_register, instantiated twice.
  - lfsr_injrate: NUM_BITS = $bits(InjectionRate).
  - lfsr_prio: NUM_BITS = $bits(Priority).
  - No new sub-module is needed.

Test Plan:
- injrate = all-ones, CONST base 5, num_packets 4, ready tied 1, phase high at cycle 0 -> enqueues on cycles 1-4 with pointers {0,0}..{0,3}, all priorities 5; o__done = 1 from cycle 5; o__num_pkts_sent = 4.
- injrate 0, phase high for 100 cycles -> zero enqueues, state stays ACTIVE, o__done stays 0.
- INCR base 250, 8-bit Priority, num_packets 10, full rate -> priorities 250..255 then 0..3 (wrap).
- Full rate with i__pifo_ready toggling every other cycle, num_packets 6 -> exactly 6 enqueues only on ready cycles, seq contiguous 0..5, done after the 6th.
- Drop phase for 5 cycles mid-run (after 2 sends), then restore -> no enqueues during the gap, seq resumes at 2, LFSR sequence identical to an un-paused run.
- Reset asserted in ACTIVE after 3 sends, then released with phase high -> sent 0, seq 0, state IDLE, and the rerun reproduces the identical pointer/priority stream (RANDOM mode, mask 0x0F).
